// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem request/handshake, IF/ID pipeline register,
// stall skid buffer and redirect handling. Optional perf counters under IF_PERF_CNT_EN.
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_FETCH | request outstanding at pc; accept, skid, drop or wait on imem_ready
// S_HOLD  | fetched word parked in skid while decode is stalled; no request
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_MUXPC_Address,
  input  logic [1:0]  in_pc_src,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] out_Add4_PC_4,
  output logic [31:0] out_IF_ID_PC_4,
  output logic [31:0] out_IF_ID_Instr,
  output logic        out_IF_ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc;
  logic [31:0] pc_4;
  logic [31:0] skid_pc_4;
  logic [31:0] skid_instr;
  logic [31:0] redirect_pc;
  logic        redirect_pend;
  logic        redirect;

  logic        ifid_ld_fetch;
  logic        ifid_ld_skid;
  logic        ifid_flush;
  logic        skid_ld;
  logic        pc_ld_mux;
  logic        pc_ld_redirect;
  logic        pend_set;
  logic        pend_clr;

  assign redirect      = (in_pc_src != 2'b00);
  assign pc_4          = pc + 32'd4;
  assign imem_addr     = pc;
  assign out_Add4_PC_4 = pc_4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // A pending redirect turns the next ready into a drop, so it never parks in HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (!redirect && !redirect_pend && imem_ready && stall) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect || !stall) begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req       = 1'b0;
    ifid_ld_fetch  = 1'b0;
    ifid_ld_skid   = 1'b0;
    ifid_flush     = 1'b0;
    skid_ld        = 1'b0;
    pc_ld_mux      = 1'b0;
    pc_ld_redirect = 1'b0;
    pend_set       = 1'b0;
    pend_clr       = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          ifid_flush = 1'b1;
          if (imem_ready) begin
            pc_ld_mux = 1'b1;
            pend_clr  = 1'b1;
          end else begin
            pend_set = 1'b1;
          end
        end else if (imem_ready) begin
          if (redirect_pend) begin
            pc_ld_redirect = 1'b1;
            pend_clr       = 1'b1;
          end else if (stall) begin
            skid_ld = 1'b1;
          end else begin
            ifid_ld_fetch = 1'b1;
            pc_ld_mux     = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          pc_ld_mux  = 1'b1;
        end else if (!stall) begin
          ifid_ld_skid = 1'b1;
          pc_ld_mux    = 1'b1;
        end
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (pc_ld_redirect) begin
      pc <= redirect_pc;
    end else if (pc_ld_mux) begin
      pc <= in_MUXPC_Address;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_IF_ID_PC_4  <= 32'h0;
      out_IF_ID_Instr <= NOP_INSTR;
      out_IF_ID_valid <= 1'b0;
    end else if (ifid_flush) begin
      out_IF_ID_PC_4  <= 32'h0;
      out_IF_ID_Instr <= NOP_INSTR;
      out_IF_ID_valid <= 1'b0;
    end else if (ifid_ld_fetch) begin
      out_IF_ID_PC_4  <= pc_4;
      out_IF_ID_Instr <= imem_rdata;
      out_IF_ID_valid <= 1'b1;
    end else if (ifid_ld_skid) begin
      out_IF_ID_PC_4  <= skid_pc_4;
      out_IF_ID_Instr <= skid_instr;
      out_IF_ID_valid <= 1'b1;
    end
  end

  // Skid occupancy is implied by S_HOLD; the data is cleared on flush so nothing stale lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_pc_4  <= 32'h0;
      skid_instr <= NOP_INSTR;
    end else if (ifid_flush) begin
      skid_pc_4  <= 32'h0;
      skid_instr <= NOP_INSTR;
    end else if (skid_ld) begin
      skid_pc_4  <= pc_4;
      skid_instr <= imem_rdata;
    end
  end

  // Newest redirect target wins while the abandoned fetch is still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc   <= RESET_PC;
      redirect_pend <= 1'b0;
    end else if (pend_set) begin
      redirect_pc   <= in_MUXPC_Address;
      redirect_pend <= 1'b1;
    end else if (pend_clr) begin
      redirect_pend <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (ifid_ld_fetch || ifid_ld_skid) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] in_MUXPC_Address;
  logic [1:0]  in_pc_src;
  logic        stall;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] out_Add4_PC_4;
  logic [31:0] out_IF_ID_PC_4;
  logic [31:0] out_IF_ID_Instr;
  logic        out_IF_ID_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // reference model: where the fetch stage is and what decode currently sees
  logic [31:0] m_pc;
  bit          m_parked;
  logic [31:0] m_park_pc4;
  logic [31:0] m_park_word;
  logic [31:0] m_pend_q[$];
  logic [31:0] m_dec_pc4;
  logic [31:0] m_dec_instr;
  bit          m_dec_valid;
  logic [31:0] m_n_fetch;
  logic [31:0] m_n_stall;

  if_fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .in_MUXPC_Address (in_MUXPC_Address),
    .in_pc_src        (in_pc_src),
    .stall            (stall),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .out_Add4_PC_4    (out_Add4_PC_4),
    .out_IF_ID_PC_4   (out_IF_ID_PC_4),
    .out_IF_ID_Instr  (out_IF_ID_Instr),
    .out_IF_ID_valid  (out_IF_ID_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc        = 32'h0;
    m_parked    = 1'b0;
    m_park_pc4  = 32'h0;
    m_park_word = 32'h0;
    m_pend_q.delete();
    m_dec_pc4   = 32'h0;
    m_dec_instr = 32'h0;
    m_dec_valid = 1'b0;
    m_n_fetch   = 32'h0;
    m_n_stall   = 32'h0;
  endtask

  task automatic flush_decode();
    m_dec_pc4   = 32'h0;
    m_dec_instr = 32'h0;
    m_dec_valid = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] pc4, input logic [31:0] word);
    m_dec_pc4   = pc4;
    m_dec_instr = word;
    m_dec_valid = 1'b1;
    m_n_fetch   = m_n_fetch + 32'd1;
  endtask

  // One rising edge of the fetch stage, described in terms of the transactions it performs.
  task automatic model_edge(input logic rdy, input logic stl, input logic [1:0] src,
                            input logic [31:0] mux, input logic [31:0] rd);
    bit redir;
    redir = (src != 2'b00);
    if (stl) m_n_stall = m_n_stall + 32'd1;
    if (m_parked) begin
      if (redir) begin
        flush_decode();
        m_parked = 1'b0;
        m_pc     = mux;
      end else if (!stl) begin
        deliver(m_park_pc4, m_park_word);
        m_parked = 1'b0;
        m_pc     = mux;
      end
    end else if (redir) begin
      flush_decode();
      if (rdy) begin
        m_pend_q.delete();
        m_pc = mux;
      end else begin
        m_pend_q.delete();
        m_pend_q.push_back(mux);
      end
    end else if (rdy) begin
      if (m_pend_q.size() != 0) begin
        m_pc = m_pend_q.pop_front();
      end else if (stl) begin
        m_park_pc4  = m_pc + 32'd4;
        m_park_word = rd;
        m_parked    = 1'b1;
      end else begin
        deliver(m_pc + 32'd4, rd);
        m_pc = mux;
      end
    end
  endtask

  task automatic check_decode();
    chk("ifid_pc4", out_IF_ID_PC_4, m_dec_pc4);
    chk("ifid_instr", out_IF_ID_Instr, m_dec_instr);
    chk("ifid_valid", {31'b0, out_IF_ID_valid}, {31'b0, m_dec_valid});
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, m_n_fetch);
    chk("perf_stall", perf_stall_cnt, m_n_stall);
`endif
  endtask

  // Called at posedge+1; drives inputs, checks fetch-side outputs, crosses one edge, checks IF/ID.
  task automatic step(input logic rdy, input logic stl, input logic [1:0] src,
                      input logic [31:0] mux, input logic [31:0] rd);
    imem_ready       = rdy;
    stall            = stl;
    in_pc_src        = src;
    in_MUXPC_Address = mux;
    imem_rdata       = rd;
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, !m_parked});
    chk("imem_addr", imem_addr, m_pc);
    chk("add4", out_Add4_PC_4, m_pc + 32'd4);
    @(posedge clk);
    model_edge(rdy, stl, src, mux, rd);
    #1;
    check_decode();
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  initial begin
    logic [31:0] f0;
    logic [31:0] v;
    logic        r;
    logic        s;
    logic [1:0]  p;

    rst              = 1'b1;
    imem_ready       = 1'b0;
    stall            = 1'b0;
    in_pc_src        = 2'b00;
    in_MUXPC_Address = 32'h0;
    imem_rdata       = 32'h0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, out_IF_ID_valid}, 32'h0);
    chk("rst_instr", out_IF_ID_Instr, 32'h0);
    chk("rst_pc4", out_IF_ID_PC_4, 32'h0);
    rst = 1'b0;

    // zero-wait streaming 0,4,8,12
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 2'b00, m_pc + 32'd4, word_at(m_pc));
      chk("stream_pc4", out_IF_ID_PC_4, 32'(4 * (i + 1)));
      chk("stream_instr", out_IF_ID_Instr, word_at(32'(4 * i)));
    end

    // two wait states at 0x10
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 2'b00, m_pc + 32'd4, 32'hDEAD_BEEF);
      chk("wait_addr", imem_addr, 32'h10);
      chk("wait_valid", {31'b0, out_IF_ID_valid}, 32'h1);
      chk("wait_instr", out_IF_ID_Instr, word_at(32'hC));
    end
    step(1'b1, 1'b0, 2'b00, m_pc + 32'd4, word_at(m_pc));
    chk("wait_load", out_IF_ID_Instr, word_at(32'h10));

    // stream up to 0x20
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, m_pc + 32'd4, word_at(m_pc));

    // redirect while the fetch at 0x20 is outstanding
    step(1'b0, 1'b0, 2'b01, 32'h40, 32'h0);
    chk("flush_valid", {31'b0, out_IF_ID_valid}, 32'h0);
    chk("flush_addr", imem_addr, 32'h20);
    step(1'b1, 1'b0, 2'b00, 32'h24, word_at(32'h20));
    chk("drop_valid", {31'b0, out_IF_ID_valid}, 32'h0);
    chk("redir_addr", imem_addr, 32'h40);

    // stall coincident with ready parks the word
    step(1'b1, 1'b1, 2'b00, m_pc + 32'd4, 32'h8C01_0004);
    chk("skid_req", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, 32'h44, 32'h0);
    step(1'b0, 1'b0, 2'b00, 32'h44, 32'h0);
    chk("skid_instr", out_IF_ID_Instr, 32'h8C01_0004);
    chk("skid_pc4", out_IF_ID_PC_4, 32'h44);
    chk("skid_addr", imem_addr, 32'h44);

    // PC wrap at the top of the address space
    step(1'b1, 1'b0, 2'b00, 32'hFFFF_FFFC, word_at(m_pc));
    chk("wrap_add4", out_Add4_PC_4, 32'h0);
`ifdef IF_PERF_CNT_EN
    f0 = perf_fetch_cnt;
`else
    f0 = 32'h0;
`endif
    step(1'b1, 1'b0, 2'b00, m_pc + 32'd4, 32'h1234_5678);
    chk("wrap_pc4", out_IF_ID_PC_4, 32'h0);
    chk("wrap_pc", imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("wrap_perf", perf_fetch_cnt, f0 + 32'd1);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v = ($urandom_range(0, 9) < 7) ? m_pc + 32'd4 : $urandom;
      step(r, s, p, v, $urandom);
    end

    // reset asserted mid-cycle while a fetch may be outstanding
    imem_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", {31'b0, out_IF_ID_valid}, 32'h0);
    chk("mid_rst_instr", out_IF_ID_Instr, 32'h0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_req", {31'b0, imem_req}, 32'h1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, m_pc + 32'd4, word_at(m_pc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
